// File: rtl/room_thermal_model.sv
// room_thermal_model: room temperature plant; heats/cools on command, drifts to ambient when idle if ROOM_DRIFT_EN is defined.
module room_thermal_model #(
    parameter int         TICK_DIV   = 16,
    parameter int         DRIFT_DIV  = 4,
    parameter logic [4:0] AMBIENT    = 5'd15,
    parameter logic [4:0] RESET_TEMP = 5'd20
) (
    input  logic       clk_p,
    input  logic       clk_n,
    input  logic       rst_n,
    input  logic       heating,
    input  logic       cooling,
    input  logic       load,
    input  logic [4:0] load_value,
    output logic       temperature_0,
    output logic       temperature_1,
    output logic       temperature_2,
    output logic       temperature_3,
    output logic       temperature_4,
    output logic       changed,
    output logic       fault
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] COOL  = 2'b01;
    localparam logic [1:0] HEAT  = 2'b10;
    localparam logic [1:0] FAULT = 2'b11;
    localparam int PW = $clog2(TICK_DIV);

    logic [1:0]    mode;
    logic [PW-1:0] presc;
    logic [4:0]    temp;
    logic [4:0]    idle_next;
    logic [4:0]    step_next;
    logic [4:0]    temp_next;
    logic          step;
    logic          unused_ok;

    assign step = presc == PW'(TICK_DIV - 1);

`ifdef ROOM_DRIFT_EN
    localparam int DW = $clog2(DRIFT_DIV + 1);
    logic [DW-1:0] drift;
    logic          drift_wrap;

    assign unused_ok  = clk_n;
    assign drift_wrap = drift == DW'(DRIFT_DIV - 1);
    assign idle_next  = !drift_wrap ? temp :
                        temp > AMBIENT ? temp - 5'd1 :
                        temp < AMBIENT ? temp + 5'd1 : temp;

    // Count idle steps; any active heat/cool step or a load restarts the count
    always_ff @(posedge clk_p or negedge rst_n)
        if (!rst_n)
            drift <= '0;
        else if (load || (step && (mode == HEAT || mode == COOL)))
            drift <= '0;
        else if (step && mode == IDLE)
            drift <= drift_wrap ? '0 : drift + DW'(1);
`else
    assign unused_ok = clk_n | (^AMBIENT) | (DRIFT_DIV == 0);
    assign idle_next = temp;
`endif

    assign step_next = mode == HEAT ? (temp == 5'd31 ? temp : temp + 5'd1) :
                       mode == COOL ? (temp == 5'd0  ? temp : temp - 5'd1) :
                       mode == IDLE ? idle_next : temp;
    assign temp_next = load ? load_value : step ? step_next : temp;

    // Latch the command pair as the operating mode
    always_ff @(posedge clk_p or negedge rst_n)
        if (!rst_n)
            mode <= IDLE;
        else
            mode <= {heating, cooling};

    // Prescaler sets the thermal step rate; a load restarts the step period
    always_ff @(posedge clk_p or negedge rst_n)
        if (!rst_n)
            presc <= '0;
        else
            presc <= (load || step) ? '0 : presc + PW'(1);

    // Temperature register, with a pulse whenever its value actually moves
    always_ff @(posedge clk_p or negedge rst_n)
        if (!rst_n) begin
            temp    <= RESET_TEMP;
            changed <= 1'b0;
        end else begin
            temp    <= temp_next;
            changed <= temp_next != temp;
        end

    assign fault         = mode == FAULT;
    assign temperature_0 = temp[0];
    assign temperature_1 = temp[1];
    assign temperature_2 = temp[2];
    assign temperature_3 = temp[3];
    assign temperature_4 = temp[4];
endmodule

// File: tb/tb_room_thermal_model.sv
// tb_room_thermal_model: randomized and directed checks of room_thermal_model against a cycle-level reference model.
module tb_room_thermal_model;
    localparam int TICK  = 4;
    localparam int DRIFT = 2;
    localparam int AMB   = 15;
    localparam int RST_T = 20;

    logic clk_p = 1'b0;
    logic clk_n;
    logic rst_n = 1'b0;
    logic heating = 1'b0;
    logic cooling = 1'b0;
    logic load = 1'b0;
    logic [4:0] load_value = 5'd0;
    logic t0, t1, t2, t3, t4, changed, fault;
    logic [4:0] temp;
    logic [6:0] obs, expv;

    int checks = 0;
    int errors = 0;

    int m_temp = RST_T;
    int m_phase = 0;
    int m_idle = 0;
    logic m_heat = 1'b0, m_cool = 1'b0, m_changed = 1'b0, m_fault = 1'b0;

    always #5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;
    assign temp  = {t4, t3, t2, t1, t0};
    assign obs   = {fault, changed, temp};
    assign expv  = {m_fault, m_changed, m_temp[4:0]};

    room_thermal_model #(
        .TICK_DIV(TICK), .DRIFT_DIV(DRIFT), .AMBIENT(5'd15), .RESET_TEMP(5'd20)
    ) dut (
        .clk_p(clk_p), .clk_n(clk_n), .rst_n(rst_n),
        .heating(heating), .cooling(cooling), .load(load), .load_value(load_value),
        .temperature_0(t0), .temperature_1(t1), .temperature_2(t2),
        .temperature_3(t3), .temperature_4(t4),
        .changed(changed), .fault(fault)
    );

    task automatic model_reset();
        m_temp = RST_T; m_phase = 0; m_idle = 0;
        m_heat = 1'b0; m_cool = 1'b0; m_changed = 1'b0; m_fault = 1'b0;
    endtask

    // advance one clock edge, evolving the reference model from the inputs seen at that edge
    task automatic cyc();
        int prev;
        @(posedge clk_p);
        prev = m_temp;
        if (load) begin
            m_temp = int'(load_value); m_phase = 0; m_idle = 0;
        end else begin
            m_phase = (m_phase + 1) % TICK;
            if (m_phase == 0) begin
                if (m_heat && !m_cool) begin
                    if (m_temp < 31) m_temp++;
                    m_idle = 0;
                end else if (!m_heat && m_cool) begin
                    if (m_temp > 0) m_temp--;
                    m_idle = 0;
                end else if (!m_heat && !m_cool) begin
                    m_idle++;
`ifdef ROOM_DRIFT_EN
                    if (m_idle == DRIFT) begin
                        m_idle = 0;
                        if (m_temp > AMB) m_temp--;
                        else if (m_temp < AMB) m_temp++;
                    end
`endif
                end
            end
        end
        m_changed = m_temp != prev;
        m_fault = heating && cooling;
        m_heat = heating;
        m_cool = cooling;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_p);
        #1;
        checks++;
        if (temp !== 5'd20) begin errors++; $display("FAIL reset_temp: got %0d expected 20", temp); end
        checks++;
        if ({changed, fault} !== 2'b00) begin errors++; $display("FAIL reset_flags: got changed=%b fault=%b expected 0 0", changed, fault); end
    endtask

    task automatic test_heat_from_reset();
        int pulses = 0;
        heating = 1'b1; cooling = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc();
            pulses += int'(changed);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL heat_cycle %0d: got %h expected %h", i, obs, expv); end
            if (i == 4) begin
                checks++;
                if (temp !== 5'd21) begin errors++; $display("FAIL heat_edge4: got %0d expected 21", temp); end
            end
        end
        checks++;
        if (temp !== 5'd24) begin errors++; $display("FAIL heat_edge16: got %0d expected 24", temp); end
        checks++;
        if (pulses != 4) begin errors++; $display("FAIL heat_pulses: got %0d expected 4", pulses); end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        load = 1'b1; load_value = 5'd30; heating = 1'b1; cooling = 1'b0;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            pulses += int'(changed);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL sat_hi_cycle %0d: got %h expected %h", i, obs, expv); end
        end
        checks++;
        if (temp !== 5'd31 || pulses != 1) begin errors++; $display("FAIL sat_hi: got temp %0d pulses %0d expected 31 and 1", temp, pulses); end
        pulses = 0;
        load = 1'b1; load_value = 5'd1; heating = 1'b0; cooling = 1'b1;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            pulses += int'(changed);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL sat_lo_cycle %0d: got %h expected %h", i, obs, expv); end
        end
        checks++;
        if (temp !== 5'd0 || pulses != 1) begin errors++; $display("FAIL sat_lo: got temp %0d pulses %0d expected 0 and 1", temp, pulses); end
    endtask

    task automatic test_fault();
        load = 1'b1; load_value = 5'd22; heating = 1'b1; cooling = 1'b1;
        cyc();
        load = 1'b0;
        checks++;
        if (fault !== 1'b1) begin errors++; $display("FAIL fault_assert: got %b expected 1", fault); end
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL fault_cycle %0d: got %h expected %h", i, obs, expv); end
        end
        checks++;
        if (temp !== 5'd22) begin errors++; $display("FAIL fault_frozen: got %0d expected 22", temp); end
        cooling = 1'b0;
        cyc();
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b expected 0", fault); end
        repeat (TICK) cyc();
        checks++;
        if (temp !== 5'd23) begin errors++; $display("FAIL fault_resume: got %0d expected 23", temp); end
    endtask

    task automatic test_drift();
`ifdef ROOM_DRIFT_EN
        localparam logic [4:0] DOWN_END = 5'd15;
        localparam logic [4:0] UP_END   = 5'd15;
`else
        localparam logic [4:0] DOWN_END = 5'd20;
        localparam logic [4:0] UP_END   = 5'd12;
`endif
        load = 1'b1; load_value = 5'd20; heating = 1'b0; cooling = 1'b0;
        cyc();
        load = 1'b0;
        for (int i = 1; i <= 48; i++) begin
            cyc();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL drift_down_cycle %0d: got %h expected %h", i, obs, expv); end
            if (i == 40) begin
                checks++;
                if (temp !== DOWN_END) begin errors++; $display("FAIL drift_40: got %0d expected %0d", temp, DOWN_END); end
            end
        end
        checks++;
        if (temp !== DOWN_END) begin errors++; $display("FAIL drift_hold: got %0d expected %0d", temp, DOWN_END); end
        load = 1'b1; load_value = 5'd12;
        cyc();
        load = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            cyc();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL drift_up_cycle %0d: got %h expected %h", i, obs, expv); end
        end
        checks++;
        if (temp !== UP_END) begin errors++; $display("FAIL drift_up: got %0d expected %0d", temp, UP_END); end
    endtask

    task automatic test_load_on_step();
        load = 1'b1; load_value = 5'd10; heating = 1'b1; cooling = 1'b0;
        cyc();
        load = 1'b0;
        repeat (TICK - 1) cyc();
        load = 1'b1; load_value = 5'd25;
        cyc();
        load = 1'b0;
        checks++;
        if (temp !== 5'd25) begin errors++; $display("FAIL load_on_step: got %0d expected 25", temp); end
        for (int i = 1; i <= TICK; i++) begin
            cyc();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL load_step_cycle %0d: got %h expected %h", i, obs, expv); end
        end
        checks++;
        if (temp !== 5'd26) begin errors++; $display("FAIL load_next_inc: got %0d expected 26", temp); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                heating = 1'($urandom_range(0, 1));
                cooling = 1'($urandom_range(0, 1));
            end
            load = $urandom_range(0, 15) == 0;
            load_value = 5'($urandom_range(0, 31));
            cyc();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL random_cycle %0d: got %h expected %h", i, obs, expv); end
        end
        load = 1'b0;
    endtask

    task automatic test_midreset();
        load = 1'b1; load_value = 5'd27; heating = 1'b1; cooling = 1'b1;
        cyc();
        load = 1'b0;
        repeat (2) cyc();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({fault, changed, temp} !== {2'b00, 5'd20}) begin errors++; $display("FAIL midreset: got %h expected %h", obs, {2'b00, 5'd20}); end
        #1 rst_n = 1'b1;
        heating = 1'b0; cooling = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL post_reset_cycle %0d: got %h expected %h", i, obs, expv); end
        end
    endtask

    initial begin
        test_reset();
        test_heat_from_reset();
        test_saturation();
        test_fault();
        test_drift();
        test_load_on_step();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/room_thermal_model.md
# room_thermal_model

Synthesisable room-temperature plant for the thermostat exercises. It is the source end of the thermostat's temperature bus: it drives `temperature_0`..`temperature_4` and consumes the thermostat's `heating`/`cooling` commands. Temperature rises while heating is commanded and falls while cooling is commanded, and otherwise drifts toward ambient. With the thermostat, it closes the control loop on-chip for bench and board demos.

## Interface
- `TICK_DIV`, 16: clock cycles per thermal step (≥2).
- `DRIFT_DIV`, 4: idle thermal steps per one-degree ambient drift (≥1).
- `AMBIENT`, 5'd15: ambient temperature, in °C.
- `RESET_TEMP`, 5'd20: temperature after reset, in °C.

- `clk_p`  in  1  differential clock, positive leg; all logic on rising edge.
- `clk_n`  in  1  differential clock, negative leg; unused internally.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `heating`  in  1  heat command from thermostat.
- `cooling`  in  1  cool command from thermostat.
- `load`  in  1  synchronous preset strobe.
- `load_value`  in  5  preset temperature, in °C.
- `temperature_0`..`temperature_4`  out  1 each  current temperature, unsigned, bit 0 = LSB.
- `changed`  out  1  one-cycle pulse; high in the first cycle a new temperature is visible.
- `fault`  out  1  high while `heating` and `cooling` are both commanded.

## Operation
- Mode register, updated every clock from the inputs:
  - `{heating,cooling}`=10 → HEAT
  - 01 → COOL
  - 00 → IDLE
  - 11 → FAULT
- Prescaler counts 0..`TICK_DIV`-1 and wraps. A step occurs on the edge where the prescaler equals `TICK_DIV`-1. The step uses the mode register value held before that edge.
- At a step, by mode:
  - HEAT: temp+1, saturating at 31. Drift counter cleared.
  - COOL: temp−1, saturating at 0. Drift counter cleared.
  - FAULT: temp held. Drift counter held.
  - IDLE: drift counter +1. When it reaches `DRIFT_DIV`, it clears and temp moves 1 toward `AMBIENT`. Temp is held if already equal to `AMBIENT`.
- `fault` is the registered FAULT mode: it asserts one cycle after both commands are high and clears one cycle after either drops.
- `load` has priority over everything:
  - temp ← `load_value`.
  - Prescaler and drift counter cleared.
  - Mode still updates.
- `changed`=1 only when the registered temperature actually differs from its previous value. This covers step and load. There is no pulse on saturation, on ambient hold, or on a load of an equal value.
- 5-bit arithmetic only; no wrap from 31 to 0 or from 0 to 31.

## Timing
- Reset (asynchronous, immediate on `rst_n` low):
  - temperature = `RESET_TEMP`
  - `changed` = 0, `fault` = 0
  - prescaler = 0, drift counter = 0, mode = IDLE
- Mid-operation reset aborts any pending step. The first step after release occurs on the `TICK_DIV`-th rising edge.
- Command-to-effect latency: 1 cycle into the mode register, then up to `TICK_DIV` cycles to the next step.
- Temperature outputs are registered and valid in the cycle after the step or load edge. `changed` is high in that same cycle.
- `load` coincident with a step: the load wins and the step is discarded.

## Configuration
- `ROOM_DRIFT_EN` defined: IDLE ambient drift is active as described above.
- `ROOM_DRIFT_EN` undefined:
  - IDLE holds the temperature indefinitely.
  - The drift counter and the `DRIFT_DIV`/`AMBIENT` logic are not built.
  - All other behaviour is unchanged.

## Test plan
All scenarios use `TICK_DIV`=4, `DRIFT_DIV`=2, `AMBIENT`=15, `RESET_TEMP`=20.
- Reset release with `heating`=1 held → temp 21 after edge 4, 24 after edge 16. `changed` pulses once per step; `fault`=0.
- Load 30, `heating`=1 → 31 after one step, then held at 31 with no further `changed` pulses. Load 1, `cooling`=1 → 0 after one step, then held at 0.
- `heating`=`cooling`=1 from temp 22 → `fault`=1 one cycle later and temp frozen at 22 across 3 steps. Drop `cooling` → `fault`=0 next cycle, then temp 23 at the next step.
- IDLE from 20 with `ROOM_DRIFT_EN` → temp −1 every 8 cycles, reaching 15 after 40 cycles and holding there. Without the macro, temp stays at 20.
- Load 25 asserted on the same edge as a scheduled step under HEAT → temp 25, not 26. The next increment is 4 cycles later.
- `rst_n` pulled low mid-count at temp 27 → outputs read 20 and `fault`=0 before the next clock edge.
